bitlock_enforce: RTL and testbench
==================================

Name: bitlock_enforce

Overview:
Consumes the DNA-lock result flags (MATCH and CHECK_DONE) produced in the configuration-clock domain and turns them into a sticky, glitch-filtered run/hold decision in the system clock domain.
- Drives the core enable, a fail flag, a 2-bit status code and a status LED.
- A missing result (check never completes) or a mismatch leads to a bounded grace period, followed by a permanent hold until reset.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per async input; legal range 2..4.
- FILTER_LEN, 4: consecutive synchronized CHECK_DONE=1 cycles required before a decision is taken; must be ≥1.
- TIMEOUT_CYCLES, 1000000: cycles in WAIT before a forced failure; 0 disables the timeout.
- GRACE_CYCLES, 50000000: cycles spent in GRACE before DENY; must be ≥1.
- BLINK_BIT, 23: free-running counter bit that drives the LED blink.

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: reset, asynchronous assert, active-low.
- MATCH_IN, in, 1: DNA-match flag, asynchronous to CLK.
- DONE_IN, in, 1: DNA-check-complete flag, asynchronous to CLK.
- ENABLE_OUT, out, 1: core run enable.
- FAIL_OUT, out, 1: lock failure (GRACE or DENY).
- STATE_OUT, out, 2: WAIT=00, GRANT=01, GRACE=10, DENY=11.
- LED_OUT, out, 1: status LED.

Behaviour:
- Reset:
  - One clock (CLK); reset RST_N is asynchronous and active-low.
  - Every flop, counter and output clears on reset.
  - Outputs in reset: ENABLE_OUT=0, FAIL_OUT=0, STATE_OUT=00, LED_OUT=0.
  - State returns to WAIT; RST_N asserted mid-operation aborts any state or count immediately.
- Synchronizers: MATCH_IN and DONE_IN each pass through a SYNC_STAGES flop chain, giving match_s and done_s. No other logic touches the raw inputs.
- Filter:
  - qual_cnt increments each cycle done_s=1 and clears to 0 when done_s=0.
  - A decision event fires in the cycle where done_s=1 and qual_cnt==FILTER_LEN-1. The verdict is match_s in that same cycle.
  - qual_cnt saturates at FILTER_LEN-1.
  - Net latency: the state changes on edge SYNC_STAGES+FILTER_LEN, counted from the first edge that samples DONE_IN=1.
- State machine (registered; outputs decoded from state, so no extra latency):
  - WAIT:
    - decision with verdict 1 → GRANT.
    - decision with verdict 0 → GRACE.
    - TIMEOUT_CYCLES≠0 and to_cnt==TIMEOUT_CYCLES-1 with no decision → GRACE.
    - to_cnt increments every cycle in WAIT.
    - A decision and the timeout in the same cycle: the decision wins.
  - GRANT: terminal until reset. Later changes on MATCH_IN or DONE_IN are ignored.
  - GRACE: gr_cnt increments from 0; at gr_cnt==GRACE_CYCLES-1 → DENY.
  - DENY: terminal until reset.
- Output decode:
  - ENABLE_OUT=1 in GRANT and GRACE.
  - FAIL_OUT=1 in GRACE and DENY.
  - LED_OUT: 0 in WAIT, 1 in GRANT, blk_cnt[BLINK_BIT] in GRACE and DENY.
- Counters:
  - blk_cnt is free-running, BLINK_BIT+1 bits wide, and wraps.
  - to_cnt and gr_cnt are $clog2(max(N,2)) bits wide and hold their value outside their own state.
- DONE_IN dropping before the filter completes restarts qualification; to_cnt is not reset.
- DONE_IN=1 already present at reset release is treated as a normal rising input.

Optional Feature:
- Macro: BITLOCK_BYPASS_EN.
- When defined:
  - ENABLE_OUT is forced to 1 in every state once reset is released.
  - The state machine, FAIL_OUT, STATE_OUT and LED_OUT still report the true verdict, so development bitstreams run on any device.
- When undefined: ENABLE_OUT follows the decode above.

Test Plan:
Bench parameters: SYNC_STAGES=2, FILTER_LEN=4, TIMEOUT_CYCLES=100, GRACE_CYCLES=50, BLINK_BIT=2.
1. Match pass: hold MATCH_IN=1, DONE_IN=1 from edge 1 → STATE_OUT=01 and ENABLE_OUT=1 at edge 6; both stay set after the inputs return to 0; FAIL_OUT=0; LED_OUT=1.
2. Mismatch: MATCH_IN=0, DONE_IN=1 → GRACE at edge 6 (ENABLE_OUT=1, FAIL_OUT=1, LED_OUT toggles every 4 cycles) → DENY 50 cycles later (ENABLE_OUT=0, STATE_OUT=11).
3. Timeout: DONE_IN held 0 → GRACE at cycle 100 after reset release, then DENY at cycle 150.
4. Glitch: DONE_IN high for 3 cycles then low, then high for 6 cycles with MATCH_IN=1 → no decision from the first pulse; GRANT on edge 6 of the second pulse.
5. Collision: DONE_IN timed so the decision lands on to_cnt==99 with MATCH_IN=1 → GRANT, not GRACE.
6. Reset and bypass: assert RST_N=0 in GRACE → all outputs 0 at once. With BITLOCK_BYPASS_EN defined, rerun scenario 3 → ENABLE_OUT=1 throughout, STATE_OUT reaches 11.

Source files
------------

// File: rtl/bitlock_enforce.sv
// DNA-lock run/hold enforcer: synchronizes MATCH/DONE, filters DONE and latches a sticky verdict.
// Optional build macro BITLOCK_BYPASS_EN keeps ENABLE_OUT high after reset while still reporting the verdict.
module bitlock_enforce #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GRACE_CYCLES   = 50000000,
  parameter int BLINK_BIT      = 23
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       MATCH_IN,
  input  logic       DONE_IN,
  output logic       ENABLE_OUT,
  output logic       FAIL_OUT,
  output logic [1:0] STATE_OUT,
  output logic       LED_OUT
);

  localparam int QUAL_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int GR_W   = (GRACE_CYCLES < 2) ? 1 : $clog2(GRACE_CYCLES);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [GR_W-1:0]   GR_LAST   = GR_W'(GRACE_CYCLES - 1);
  localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GRACE = 2'b10,
    ST_DENY  = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] match_sync_reg, done_sync_reg;
  logic [QUAL_W-1:0]      qual_cnt_reg;
  logic [TO_W-1:0]        to_cnt_reg;
  logic [GR_W-1:0]        gr_cnt_reg;
  logic [BLINK_BIT:0]     blk_cnt_reg;

  logic match_s, done_s, decision, timeout_hit;
  logic core_enable;

  assign match_s = match_sync_reg[SYNC_STAGES-1];
  assign done_s  = done_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      match_sync_reg <= '0;
      done_sync_reg  <= '0;
    end else begin
      match_sync_reg <= {match_sync_reg[SYNC_STAGES-2:0], MATCH_IN};
      done_sync_reg  <= {done_sync_reg[SYNC_STAGES-2:0], DONE_IN};
    end
  end

  // Run-length of done_s, saturating so a held DONE keeps the decision asserted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qual_cnt_reg <= '0;
    end else if (!done_s) begin
      qual_cnt_reg <= '0;
    end else if (qual_cnt_reg != QUAL_LAST) begin
      qual_cnt_reg <= qual_cnt_reg + QUAL_W'(1);
    end
  end

  assign decision    = done_s && (qual_cnt_reg == QUAL_LAST);
  assign timeout_hit = TO_EN && (to_cnt_reg == TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_WAIT;
      to_cnt_reg  <= '0;
      gr_cnt_reg  <= '0;
      blk_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      blk_cnt_reg <= blk_cnt_reg + (BLINK_BIT + 1)'(1);
      if (state_reg == ST_WAIT) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
      if (state_reg == ST_GRACE) begin
        gr_cnt_reg <= gr_cnt_reg + GR_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    core_enable = 1'b0;
    FAIL_OUT    = 1'b0;
    LED_OUT     = 1'b0;
    STATE_OUT   = state_reg;
    case (state_reg)
      ST_WAIT: begin
        // A decision outranks a timeout landing on the same cycle.
        if (decision) begin
          state_next = match_s ? ST_GRANT : ST_GRACE;
        end else if (timeout_hit) begin
          state_next = ST_GRACE;
        end
      end
      ST_GRANT: begin
        core_enable = 1'b1;
        LED_OUT     = 1'b1;
      end
      ST_GRACE: begin
        core_enable = 1'b1;
        FAIL_OUT    = 1'b1;
        LED_OUT     = blk_cnt_reg[BLINK_BIT];
        if (gr_cnt_reg == GR_LAST) begin
          state_next = ST_DENY;
        end
      end
      ST_DENY: begin
        FAIL_OUT = 1'b1;
        LED_OUT  = blk_cnt_reg[BLINK_BIT];
      end
      default: state_next = ST_WAIT;
    endcase
  end

`ifdef BITLOCK_BYPASS_EN
  logic bypass_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bypass_reg <= 1'b0;
    end else begin
      bypass_reg <= 1'b1;
    end
  end

  assign ENABLE_OUT = bypass_reg;

  logic unused_enable;
  assign unused_enable = core_enable;
`else
  assign ENABLE_OUT = core_enable;
`endif

endmodule

// File: tb/tb_bitlock_enforce.sv
// Directed bench for bitlock_enforce: edge-indexed behavioural model checked every cycle plus literal checkpoints.
module tb_bitlock_enforce;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TO   = 100;
  localparam int GR   = 50;
  localparam int BB   = 2;
`ifdef BITLOCK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       MATCH_IN = 1'b0;
  logic       DONE_IN = 1'b0;
  logic       ENABLE_OUT;
  logic       FAIL_OUT;
  logic [1:0] STATE_OUT;
  logic       LED_OUT;

  bitlock_enforce #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TO),
    .GRACE_CYCLES  (GR),
    .BLINK_BIT     (BB)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .MATCH_IN  (MATCH_IN),
    .DONE_IN   (DONE_IN),
    .ENABLE_OUT(ENABLE_OUT),
    .FAIL_OUT  (FAIL_OUT),
    .STATE_OUT (STATE_OUT),
    .LED_OUT   (LED_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: edges are numbered from reset release; inputs sampled at edge k are stored at index k-1.
  int m_e, m_state, m_gstart, m_s;
  bit m_dec;
  bit d_q[$];
  bit m_q[$];
  int e_en, e_fail, e_state, e_led;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_e = 0;
      m_state = 0;
      m_gstart = 0;
      d_q.delete();
      m_q.delete();
    end else begin
      m_e++;
      d_q.push_back(DONE_IN);
      m_q.push_back(MATCH_IN);
      if (m_state == 0) begin
        // Decision at edge e needs FILT consecutive DONE samples ending at edge e-SYNC.
        m_s = m_e - SYNC;
        m_dec = (m_s - FILT + 1 >= 1);
        for (int k = m_s - FILT + 1; k <= m_s; k++) begin
          if (k >= 1 && !d_q[k-1]) m_dec = 1'b0;
        end
        if (m_dec) begin
          m_state = m_q[m_s-1] ? 1 : 2;
          m_gstart = m_e;
        end else if (TO != 0 && m_e == TO) begin
          m_state = 2;
          m_gstart = m_e;
        end
      end else if (m_state == 2 && m_e == m_gstart + GR) begin
        m_state = 3;
      end
    end
    #1;
    if (!RST_N) begin
      e_en = 0; e_fail = 0; e_state = 0; e_led = 0;
    end else begin
      e_state = m_state;
      e_en    = BYP ? 1 : ((m_state == 1 || m_state == 2) ? 1 : 0);
      e_fail  = (m_state >= 2) ? 1 : 0;
      e_led   = (m_state == 0) ? 0 : (m_state == 1) ? 1 : ((m_e >> BB) & 1);
    end
    chk("cyc_enable", ENABLE_OUT, e_en);
    chk("cyc_fail",   FAIL_OUT,   e_fail);
    chk("cyc_state",  STATE_OUT,  e_state);
    chk("cyc_led",    LED_OUT,    e_led);
  end

  int cur;

  task automatic start(input bit m, input bit d);
    RST_N = 1'b0;
    MATCH_IN = 1'b0;
    DONE_IN = 1'b0;
    repeat (3) @(negedge CLK);
    MATCH_IN = m;
    DONE_IN = d;
    RST_N = 1'b1;
    cur = 0;
  endtask

  task automatic at(input int n);
    while (cur < n) begin
      @(posedge CLK);
      cur++;
    end
    #2;
  endtask

  task automatic drive(input int k, input bit m, input bit d);
    at(k - 1);
    @(negedge CLK);
    MATCH_IN = m;
    DONE_IN = d;
  endtask

  initial begin
    // 1: match pass
    start(1'b1, 1'b1);
    at(5);  chk("s1_state_e5", STATE_OUT, 0);
    at(6);  chk("s1_state_e6", STATE_OUT, 1);
            chk("s1_enable_e6", ENABLE_OUT, 1);
            chk("s1_fail_e6", FAIL_OUT, 0);
            chk("s1_led_e6", LED_OUT, 1);
    drive(10, 1'b0, 1'b0);
    at(30); chk("s1_state_sticky", STATE_OUT, 1);
            chk("s1_enable_sticky", ENABLE_OUT, BYP ? 1 : 1);

    // 2: mismatch -> grace -> deny
    start(1'b0, 1'b1);
    at(6);  chk("s2_state_e6", STATE_OUT, 2);
            chk("s2_enable_e6", ENABLE_OUT, 1);
            chk("s2_fail_e6", FAIL_OUT, 1);
            chk("s2_led_e6", LED_OUT, 1);
    at(8);  chk("s2_led_e8", LED_OUT, 0);
    at(55); chk("s2_state_e55", STATE_OUT, 2);
    at(56); chk("s2_state_e56", STATE_OUT, 3);
            chk("s2_enable_e56", ENABLE_OUT, BYP ? 1 : 0);

    // 3: timeout
    start(1'b0, 1'b0);
    at(99);  chk("s3_state_e99", STATE_OUT, 0);
    at(100); chk("s3_state_e100", STATE_OUT, 2);
    at(149); chk("s3_state_e149", STATE_OUT, 2);
    at(150); chk("s3_state_e150", STATE_OUT, 3);

    // 4: glitch then real pulse
    start(1'b1, 1'b1);
    drive(4, 1'b1, 1'b0);
    at(9);  chk("s4_state_e9", STATE_OUT, 0);
    drive(10, 1'b1, 1'b1);
    at(14); chk("s4_state_e14", STATE_OUT, 0);
    at(15); chk("s4_state_e15", STATE_OUT, 1);
    drive(16, 1'b1, 1'b0);
    at(20); chk("s4_state_e20", STATE_OUT, 1);

    // 5: decision coincides with timeout
    start(1'b0, 1'b0);
    drive(95, 1'b1, 1'b1);
    at(99);  chk("s5_state_e99", STATE_OUT, 0);
    at(100); chk("s5_state_e100", STATE_OUT, 1);
    at(110); chk("s5_fail_e110", FAIL_OUT, 0);

    // 6: reset during grace, then timeout rerun
    start(1'b0, 1'b1);
    at(20); chk("s6_state_grace", STATE_OUT, 2);
    RST_N = 1'b0;
    #1;
    chk("s6_rst_enable", ENABLE_OUT, 0);
    chk("s6_rst_fail", FAIL_OUT, 0);
    chk("s6_rst_state", STATE_OUT, 0);
    chk("s6_rst_led", LED_OUT, 0);
    start(1'b0, 1'b0);
    at(50);  chk("s6_enable_e50", ENABLE_OUT, BYP ? 1 : 0);
    at(100); chk("s6_state_e100", STATE_OUT, 2);
             chk("s6_enable_e100", ENABLE_OUT, 1);
    at(150); chk("s6_state_e150", STATE_OUT, 3);
             chk("s6_enable_e150", ENABLE_OUT, BYP ? 1 : 0);
    at(160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
